// File: rtl/mem_stage_dual_if.sv
// Bus interface of the dual-issue memory stage: execute-side handover,
// writeback-side handover, data SRAM response, forward and store-block buses.
// The slave modport is the stage itself; the master modport is its environment.
interface mem_stage_dual_if;
    localparam int LANE_IN_W  = 77;
    localparam int LANE_OUT_W = 71;
    localparam int FWD_W      = 39;

    logic                      next_allowin_i;
    logic                      line1_pre_to_now_valid_i;
    logic                      line2_pre_to_now_valid_i;
    logic                      now_allowin_o;
    logic                      line1_now_to_next_valid_o;
    logic                      line2_now_to_next_valid_o;
    logic                      excep_flush_i;
    logic                      data_sram_data_ok_i;
    logic [31:0]               data_sram_rdata_i;
    logic [2*LANE_IN_W-1:0]    pre_to_ibus;
    logic [2*LANE_OUT_W-1:0]   to_next_obus;
    logic [2*FWD_W-1:0]        forward_obus;
    logic [1:0]                mem_to_ex_obus;

    modport slave (
        input  next_allowin_i,
        input  line1_pre_to_now_valid_i,
        input  line2_pre_to_now_valid_i,
        input  excep_flush_i,
        input  data_sram_data_ok_i,
        input  data_sram_rdata_i,
        input  pre_to_ibus,
        output now_allowin_o,
        output line1_now_to_next_valid_o,
        output line2_now_to_next_valid_o,
        output to_next_obus,
        output forward_obus,
        output mem_to_ex_obus
    );

    modport master (
        output next_allowin_i,
        output line1_pre_to_now_valid_i,
        output line2_pre_to_now_valid_i,
        output excep_flush_i,
        output data_sram_data_ok_i,
        output data_sram_rdata_i,
        output pre_to_ibus,
        input  now_allowin_o,
        input  line1_now_to_next_valid_o,
        input  line2_now_to_next_valid_o,
        input  to_next_obus,
        input  forward_obus,
        input  mem_to_ex_obus
    );
endinterface

// File: rtl/mem_stage_dual.sv
// Dual-issue memory stage: EX/MEM pipeline register for two lanes. Line1 memory
// instructions wait for the data SRAM response, whose data is byte-aligned and
// extended into the lane's write-back value. Line2 never talks to the SRAM.
// Optional feature macro MEM_STALL_CNT_EN adds a 32-bit stall cycle counter
// output mem_stall_cnt_o.
module mem_stage_dual (
    input  logic            clk,
    input  logic            rst,
    mem_stage_dual_if.slave bus
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [31:0]     mem_stall_cnt_o
`endif
);
    localparam int LANE_IN_W = 77;

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_ST  = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  rf_waddr;
        logic        rf_we;
        logic        mem_req;
        logic [2:0]  mem_op;
        logic [1:0]  addr_lo;
        logic        excp;
    } lane_in_t;

    // WAIT: a line1 request is outstanding. DISCARD: a flushed request is
    // still outstanding and its response must be swallowed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    lane_in_t    r_line1;
    lane_in_t    r_line2;
    logic        r_line1_valid;
    logic        r_line2_valid;
    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_buf;
    logic        r_data_got;

    lane_in_t    w_in1;
    lane_in_t    w_in2;
    logic        w_in_wait;
    logic        w_in_discard;
    logic        w_data_ok_now;
    logic        w_line1_mem;
    logic        w_data_avail;
    logic        w_ready_go;
    logic        w_load;
    logic        w_load_mem;
    logic [31:0] w_ld_data;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;
    logic [31:0] w_line1_wdata;
    logic        w_line1_fwd_we;
    logic        w_line2_fwd_we;
    logic        w_load_pending;
    logic        w_unused;

    assign w_in1 = bus.pre_to_ibus[LANE_IN_W-1:0];
    assign w_in2 = bus.pre_to_ibus[2*LANE_IN_W-1:LANE_IN_W];

    // Line2 memory fields are carried in the register but never acted upon.
    assign w_unused = ^{r_line2.mem_req, r_line2.mem_op, r_line2.addr_lo};

    // A response is only meaningful while a live request is outstanding.
    assign w_data_ok_now = w_in_wait & bus.data_sram_data_ok_i;

    // The response cycle itself counts as having the data: it passes straight
    // through to writeback with no extra cycle.
    assign w_line1_mem  = r_line1_valid & r_line1.mem_req & ~r_line1.excp;
    assign w_data_avail = r_data_got | w_data_ok_now;
    assign w_ready_go   = ~(w_line1_mem & ~w_data_avail);

    assign w_load = ~w_in_discard
                  & (~(r_line1_valid | r_line2_valid) | (w_ready_go & bus.next_allowin_i));

    // Only a live, exception-free line1 memory instruction issues a request.
    assign w_load_mem = w_load & bus.line1_pre_to_now_valid_i & ~bus.excep_flush_i
                      & w_in1.mem_req & ~w_in1.excp;

    assign bus.now_allowin_o             = w_load;
    assign bus.line1_now_to_next_valid_o = r_line1_valid & w_ready_go & ~bus.excep_flush_i;
    assign bus.line2_now_to_next_valid_o = r_line2_valid & w_ready_go & ~bus.excep_flush_i;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state: track the single outstanding line1 request.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load_mem) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A response in the load cycle belongs to the old instruction;
                // the newly loaded one may immediately start waiting again.
                if (bus.data_sram_data_ok_i) w_state_nxt = w_load_mem ? ST_WAIT : ST_IDLE;
                else if (bus.excep_flush_i)  w_state_nxt = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (bus.data_sram_data_ok_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: state decode used by the datapath.
    always_comb begin
        w_in_wait    = 1'b0;
        w_in_discard = 1'b0;
        case (r_state)
            ST_WAIT:    w_in_wait    = 1'b1;
            ST_DISCARD: w_in_discard = 1'b1;
            default: ;
        endcase
    end

    // Lane valids: loaded on handover, killed immediately by a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line1_valid <= 1'b0;
            r_line2_valid <= 1'b0;
        end else if (bus.excep_flush_i) begin
            r_line1_valid <= 1'b0;
            r_line2_valid <= 1'b0;
        end else if (w_load) begin
            r_line1_valid <= bus.line1_pre_to_now_valid_i;
            r_line2_valid <= bus.line2_pre_to_now_valid_i;
        end
    end

    // Lane payload registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: payload is reset too, so every output bus reads all-zero out of reset.
        if (rst) begin
            r_line1 <= '0;
            r_line2 <= '0;
        end else if (w_load) begin
            r_line1 <= w_in1;
            r_line2 <= w_in2;
        end
    end

    // Response capture: data is kept until the instruction leaves; a flushed
    // response is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf      <= '0;
            r_data_got <= 1'b0;
        end else begin
            if (w_data_ok_now && !bus.excep_flush_i) r_buf <= bus.data_sram_rdata_i;
            if (w_load)                                   r_data_got <= 1'b0;
            else if (w_data_ok_now && !bus.excep_flush_i) r_data_got <= 1'b1;
        end
    end

    // Load alignment and extension for line1.
    always_comb begin
        w_ld_data = w_data_ok_now ? bus.data_sram_rdata_i : r_buf;
        w_ld_byte = w_ld_data[7:0];
        case (r_line1.addr_lo)
            2'd1:    w_ld_byte = w_ld_data[15:8];
            2'd2:    w_ld_byte = w_ld_data[23:16];
            2'd3:    w_ld_byte = w_ld_data[31:24];
            default: w_ld_byte = w_ld_data[7:0];
        endcase
        w_ld_half = r_line1.addr_lo[1] ? w_ld_data[31:16] : w_ld_data[15:0];
        case (r_line1.mem_op)
            OP_LB:   w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
            OP_LH:   w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
            OP_LBU:  w_ld_ext = {24'd0, w_ld_byte};
            OP_LHU:  w_ld_ext = {16'd0, w_ld_half};
            OP_ST:   w_ld_ext = r_line1.result;
            default: w_ld_ext = w_ld_data;
        endcase
        w_line1_wdata = (r_line1.mem_req && r_line1.mem_op != OP_ST) ? w_ld_ext : r_line1.result;
    end

    assign w_line1_fwd_we = r_line1_valid & r_line1.rf_we & ~r_line1.excp;
    assign w_line2_fwd_we = r_line2_valid & r_line2.rf_we & ~r_line2.excp;
    assign w_load_pending = w_line1_mem & (r_line1.mem_op != OP_ST) & ~w_data_avail;

    assign bus.to_next_obus = {
        r_line2.pc, r_line2.result, r_line2.rf_waddr, r_line2.rf_we, r_line2.excp,
        r_line1.pc, w_line1_wdata,  r_line1.rf_waddr, r_line1.rf_we, r_line1.excp
    };

    assign bus.forward_obus = {
        w_line2_fwd_we, r_line2.rf_waddr, r_line2.result, 1'b0,
        w_line1_fwd_we, r_line1.rf_waddr, w_line1_wdata,  w_load_pending
    };

    assign bus.mem_to_ex_obus = {r_line2_valid & r_line2.excp, r_line1_valid & r_line1.excp};

`ifdef MEM_STALL_CNT_EN
    // Stall counter: cycles line1 is held for data or a response is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    mem_stall_cnt_o <= '0;
        else if ((r_line1_valid & ~w_ready_go) | w_in_discard) mem_stall_cnt_o <= mem_stall_cnt_o + 32'd1;
    end
`endif
endmodule
